// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexes eight 6-bit symbol codes onto an 8-digit common-anode 7-segment display.
// Each digit slot lasts REFRESH_DIV cycles. The first BLANK_CYCLES cycles of a slot are a
// blanking gap with every anode off. All eight codes are snapshotted together once per frame.
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high reset
//   en           display enable; 0 forces all anodes inactive while the scan keeps running
//   d1..d8       symbol codes, d1 = leftmost digit
//   an[7:0]      anode enables, an[7] = d1 ... an[0] = d8
//   seg[6:0]     segments a..g, seg[6] = a
//   dp           decimal point, held at its inactive level
//   frame_strobe one-cycle pulse following each snapshot load
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned BLANK_CYCLES   = 500,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [5:0] d1,
  input  logic [5:0] d2,
  input  logic [5:0] d3,
  input  logic [5:0] d4,
  input  logic [5:0] d5,
  input  logic [5:0] d6,
  input  logic [5:0] d7,
  input  logic [5:0] d8,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_strobe
);

  localparam int unsigned    CntW     = $clog2(REFRESH_DIV);
  localparam logic [CntW-1:0] CntMax   = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYCLES);
  localparam logic [7:0]     AnOff    = AN_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [6:0]     SegOff   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic           DpOff    = SEG_ACTIVE_LOW;
  localparam logic [5:0]     CodeDash = 6'b111111;

  logic [CntW-1:0] cnt_q;
  logic [2:0]      dig_q;
  logic [5:0]      snap_q [8];
  logic [5:0]      d_in   [8];

  logic       slot_end;
  logic       frame_end;
  logic       drive;
  logic [7:0] an_raw;
  logic [6:0] seg_raw;

  assign d_in[0] = d1;
  assign d_in[1] = d2;
  assign d_in[2] = d3;
  assign d_in[3] = d4;
  assign d_in[4] = d5;
  assign d_in[5] = d6;
  assign d_in[6] = d7;
  assign d_in[7] = d8;

  // Glyph decode, active-high abcdefg. code[0] is a don't-care.
  function automatic logic [6:0] decode(input logic [5:0] code);
    logic [6:0] g;
    if (code[5]) begin
      g = 7'b0000001;
    end else begin
      unique case (code[4:1])
        4'h0: g = 7'b1111110;
        4'h1: g = 7'b0110000;
        4'h2: g = 7'b1101101;
        4'h3: g = 7'b1111001;
        4'h4: g = 7'b0110011;
        4'h5: g = 7'b1011011;
        4'h6: g = 7'b1011111;
        4'h7: g = 7'b1110000;
        4'h8: g = 7'b1111111;
        4'h9: g = 7'b1111011;
        4'hA: g = 7'b1100111;
        4'hB: g = 7'b0011111;
        4'hC: g = 7'b0001101;
        4'hD: g = 7'b1011011;
        4'hE: g = 7'b1001111;
        4'hF: g = 7'b0111110;
      endcase
    end
    return g;
  endfunction

  always_comb begin
    slot_end  = (cnt_q == CntMax);
    frame_end = slot_end && (dig_q == 3'd7);
    drive     = (BLANK_CYCLES == 0) ? 1'b1 : (cnt_q >= CntBlank);
    an_raw    = 8'h00;
    seg_raw   = 7'h00;
    if (drive) begin
      seg_raw = decode(snap_q[dig_q]);
      if (en) begin
        an_raw = 8'h80 >> dig_q;  // dig 0 (d1) maps to an[7]
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      dig_q        <= 3'd0;
      for (int k = 0; k < 8; k++) snap_q[k] <= CodeDash;
      an           <= AnOff;
      seg          <= SegOff;
      dp           <= DpOff;
      frame_strobe <= 1'b0;
    end else begin
      cnt_q <= slot_end ? '0 : cnt_q + 1'b1;
      if (slot_end) dig_q <= dig_q + 3'd1;  // 7 wraps to 0 naturally
      if (frame_end) begin
        for (int k = 0; k < 8; k++) snap_q[k] <= d_in[k];
      end
      // Output stage sees the pre-edge snapshot, so the load above lands with the next frame.
      an           <= an_raw ^ AnOff;
      seg          <= seg_raw ^ SegOff;
      dp           <= DpOff;
      frame_strobe <= frame_end;
    end
  end

endmodule
